// File: rtl/dec_fpr_mbank_ctl_pkg.sv
// Shared types and constants for the banked floating-point register file.
package dec_fpr_pkg;

  localparam int FPR_NUM         = 32;
  localparam int CLEAR_PER_CYCLE = 4;
  localparam int IDX_W           = $clog2(FPR_NUM);

  // Bank-management request encodings; RSVD behaves as SWITCH.
  typedef enum logic [1:0] {
    BANK_SWITCH = 2'b00,
    BANK_COPY   = 2'b01,
    BANK_CLEAR  = 2'b10,
    BANK_RSVD   = 2'b11
  } bank_mode_e;

  // Bank-management engine states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COPY  = 2'b01,
    ST_CLEAR = 2'b10
  } fsm_state_e;

endpackage

// File: rtl/dec_fpr_mbank_ctl_if.sv
// Decode/writeback facing bus of the banked FPR: read ports, write ports and
// the bank-management request handshake.
interface dec_fpr_mbank_ctl_if #(
  parameter int FLEN      = 64,
  parameter int NREAD     = 3,
  parameter int NWRITE    = 2,
  parameter int FPR_BANKS = 4
);
  import dec_fpr_pkg::*;

  localparam int BW = $clog2(FPR_BANKS);

  logic [NREAD-1:0][IDX_W-1:0]  raddr;
  logic [NREAD-1:0]             rden;
  logic [NREAD-1:0][FLEN-1:0]   rd;
  logic [NWRITE-1:0][IDX_W-1:0] waddr;
  logic [NWRITE-1:0]            wen;
  logic [NWRITE-1:0][FLEN-1:0]  wd;
  logic                         bank_req_valid;
  logic [BW-1:0]                bank_req_id;
  bank_mode_e                   bank_req_mode;
  logic                         bank_req_ready;
  logic [BW-1:0]                cur_bank;
  logic                         busy;
  logic                         scan_mode;

  modport master (
    output raddr, rden, waddr, wen, wd,
    output bank_req_valid, bank_req_id, bank_req_mode, scan_mode,
    input  rd, bank_req_ready, cur_bank, busy
  );

  modport slave (
    input  raddr, rden, waddr, wen, wd,
    input  bank_req_valid, bank_req_id, bank_req_mode, scan_mode,
    output rd, bank_req_ready, cur_bank, busy
  );

endinterface

// File: rtl/dec_fpr_mbank_ctl_bank.sv
// One 32-entry FPR bank. Each register has its own enable; the next value is
// chosen by priority clear < copy < architectural write port 0 < port 1 < ...
module dec_fpr_bank
  import dec_fpr_pkg::*;
#(
  parameter int FLEN   = 64,
  parameter int NWRITE = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NWRITE-1:0]               i_wen,
  input  logic [NWRITE-1:0][IDX_W-1:0]    i_waddr,
  input  logic [NWRITE-1:0][FLEN-1:0]     i_wd,
  input  logic                            i_copy_en,
  input  logic [IDX_W-1:0]                i_copy_idx,
  input  logic [FLEN-1:0]                 i_copy_data,
  input  logic                            i_clr_en,
  input  logic [IDX_W-1:0]                i_clr_base,
  output logic [FPR_NUM-1:0][FLEN-1:0]    o_regs
);

  logic [FPR_NUM-1:0][FLEN-1:0] r_regs;
  logic [FPR_NUM-1:0]           w_reg_en;
  logic [FPR_NUM-1:0][FLEN-1:0] w_reg_d;

  // Per-register enable and write-data mux; later sources override earlier ones.
  always_comb begin
    // NOTE: defaults first, then blocking overrides; every path assigns, so no latch.
    w_reg_en = '0;
    w_reg_d  = '0;
    for (int r = 0; r < FPR_NUM; r++) begin
      if (i_clr_en && (r >= int'(i_clr_base)) &&
          (r < int'(i_clr_base) + CLEAR_PER_CYCLE)) begin
        w_reg_en[r] = 1'b1;
        w_reg_d[r]  = '0;
      end
      if (i_copy_en && (i_copy_idx == IDX_W'(r))) begin
        w_reg_en[r] = 1'b1;
        w_reg_d[r]  = i_copy_data;
      end
      for (int p = 0; p < NWRITE; p++) begin
        if (i_wen[p] && (i_waddr[p] == IDX_W'(r))) begin
          w_reg_en[r] = 1'b1;
          w_reg_d[r]  = i_wd[p];
        end
      end
    end
  end

  // Register storage.
  always_ff @(posedge clk) begin
    // NOTE: the array is reset because every register must read zero after reset.
    if (rst) begin
      r_regs <= '0;
    end else begin
      for (int r = 0; r < FPR_NUM; r++) begin
        // NOTE: sequential state uses non-blocking assignment only.
        if (w_reg_en[r]) r_regs[r] <= w_reg_d[r];
      end
    end
  end

  assign o_regs = r_regs;

endmodule

// File: rtl/dec_fpr_mbank_ctl.sv
// Multi-port, multi-bank FPR with a SWITCH/COPY/CLEAR bank-management engine.
module dec_fpr_mbank_ctl
  import dec_fpr_pkg::*;
#(
  parameter int FLEN      = 64,
  parameter int NREAD     = 3,
  parameter int NWRITE    = 2,
  parameter int FPR_BANKS = 4,
  parameter int BYPASS    = 1
) (
  input  logic               clk,
  input  logic               rst,
  dec_fpr_mbank_ctl_if.slave bus
);

  localparam int BW = $clog2(FPR_BANKS);

  fsm_state_e                   r_state, w_state_nxt;
  logic [IDX_W-1:0]             r_idx, w_idx_nxt;
  logic [BW-1:0]                r_cur_bank, w_cur_nxt;
  logic [BW-1:0]                r_target, w_target_nxt;
  logic                         w_accept;
  logic [FLEN-1:0]              w_copy_data;
  logic [FPR_NUM-1:0][FLEN-1:0] w_regs [FPR_BANKS];

  assign w_accept    = bus.bank_req_valid && (r_state == ST_IDLE);
  assign w_copy_data = w_regs[r_cur_bank][r_idx];

  // Next-state, index/bank bookkeeping and handshake outputs of the engine.
  always_comb begin
    w_state_nxt        = r_state;
    w_idx_nxt          = r_idx;
    w_cur_nxt          = r_cur_bank;
    w_target_nxt       = r_target;
    bus.bank_req_ready = (r_state == ST_IDLE);
    bus.busy           = (r_state != ST_IDLE);
    bus.cur_bank       = r_cur_bank;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_target_nxt = bus.bank_req_id;
          w_idx_nxt    = '0;
          case (bus.bank_req_mode)
            BANK_COPY:  w_state_nxt = ST_COPY;
            BANK_CLEAR: w_state_nxt = ST_CLEAR;
            default:    w_cur_nxt   = bus.bank_req_id;
          endcase
        end
      end
      ST_COPY: begin
        // Copy onto the active bank is a single-cycle pass with no data movement.
        if ((r_idx == IDX_W'(FPR_NUM - 1)) || (r_target == r_cur_bank)) begin
          w_state_nxt = ST_IDLE;
          w_cur_nxt   = r_target;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      ST_CLEAR: begin
        if (r_idx == IDX_W'(FPR_NUM - CLEAR_PER_CYCLE)) begin
          w_state_nxt = ST_IDLE;
          w_cur_nxt   = r_target;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(CLEAR_PER_CYCLE);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Engine state register; reset aborts any COPY/CLEAR in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_cur_bank <= '0;
      r_target   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_cur_bank <= w_cur_nxt;
      r_target   <= w_target_nxt;
    end
  end

  // Banks: writes land in the active bank and are mirrored into a COPY target.
  for (genvar b = 0; b < FPR_BANKS; b++) begin : g_bank
    logic w_is_cur;
    logic w_is_tgt;
    logic w_wr_sel;

    assign w_is_cur = (r_cur_bank == BW'(b));
    assign w_is_tgt = (r_target == BW'(b));
    assign w_wr_sel = w_is_cur || ((r_state == ST_COPY) && w_is_tgt);

    dec_fpr_bank #(
      .FLEN   (FLEN),
      .NWRITE (NWRITE)
    ) u_bank (
      .clk         (clk),
      .rst         (rst),
      .i_wen       (bus.wen & {NWRITE{w_wr_sel}}),
      .i_waddr     (bus.waddr),
      .i_wd        (bus.wd),
      .i_copy_en   ((r_state == ST_COPY) && w_is_tgt && !w_is_cur),
      .i_copy_idx  (r_idx),
      .i_copy_data (w_copy_data),
      .i_clr_en    ((r_state == ST_CLEAR) && w_is_tgt),
      .i_clr_base  (r_idx),
      .o_regs      (w_regs[b])
    );
  end

  // Read ports: active bank, optional forwarding of the winning write, zero when disabled.
  always_comb begin
    bus.rd = '0;
    for (int p = 0; p < NREAD; p++) begin
      if (bus.rden[p]) begin
        bus.rd[p] = w_regs[r_cur_bank][bus.raddr[p]];
        if (BYPASS != 0) begin
          for (int q = 0; q < NWRITE; q++) begin
            if (bus.wen[q] && (bus.waddr[q] == bus.raddr[p])) bus.rd[p] = bus.wd[q];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dec_fpr_mbank_ctl.sv
// Directed scoreboard bench for the banked FPR and its bank-management engine.
module tb_dec_fpr_mbank_ctl;
  import dec_fpr_pkg::*;

  localparam int FLEN      = 64;
  localparam int NREAD     = 3;
  localparam int NWRITE    = 2;
  localparam int FPR_BANKS = 4;
  localparam int BW        = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dec_fpr_mbank_ctl_if #(.FLEN(FLEN), .NREAD(NREAD), .NWRITE(NWRITE),
                         .FPR_BANKS(FPR_BANKS)) bus ();

  dec_fpr_mbank_ctl #(.FLEN(FLEN), .NREAD(NREAD), .NWRITE(NWRITE),
                      .FPR_BANKS(FPR_BANKS), .BYPASS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef enum int {OBS_RD, OBS_CUR, OBS_BUSY, OBS_READY} obs_e;
  typedef struct {
    string       tag;
    obs_e        sel;
    int          port;
    logic [63:0] exp;
  } sb_t;

  sb_t         sbq[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [FLEN-1:0] mdl [FPR_BANKS][32];

  function automatic logic [63:0] observe(obs_e sel, int port);
    case (sel)
      OBS_RD:   return bus.rd[port];
      OBS_CUR:  return 64'(bus.cur_bank);
      OBS_BUSY: return 64'(bus.busy);
      default:  return 64'(bus.bank_req_ready);
    endcase
  endfunction

  task automatic expect_val(string tag, obs_e sel, int port, logic [63:0] exp);
    sb_t e;
    e.tag = tag; e.sel = sel; e.port = port; e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    logic [63:0] o;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = observe(e.sel, e.port);
      vectors++;
      assert (o === e.exp) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #2;
    drain();
  endtask

  task automatic idle();
    bus.wen = '0; bus.rden = '0; bus.raddr = '0; bus.waddr = '0; bus.wd = '0;
    bus.bank_req_valid = 1'b0; bus.bank_req_id = '0; bus.bank_req_mode = BANK_SWITCH;
    bus.scan_mode = 1'b0;
  endtask

  task automatic expect_status(string tag, int cur, bit busy);
    expect_val({tag, " cur"}, OBS_CUR, 0, 64'(cur));
    expect_val({tag, " busy"}, OBS_BUSY, 0, 64'(busy));
    expect_val({tag, " ready"}, OBS_READY, 0, 64'(!busy));
  endtask

  task automatic read_all(string tag, int b);
    for (int j = 0; j < 11; j++) begin
      cyc(); idle();
      for (int p = 0; p < NREAD; p++) begin
        int a;
        a = (3 * j + p > 31) ? 31 : 3 * j + p;
        bus.raddr[p] = 5'(a);
        bus.rden[p]  = 1'b1;
        expect_val($sformatf("%s b%0d f%0d", tag, b, a), OBS_RD, p, mdl[b][a]);
      end
      sample();
    end
  endtask

  // Fill bank b (must be active) with base + i, or all-ones when ones is set.
  task automatic fill(int b, logic [63:0] base, bit ones);
    for (int i = 0; i < 16; i++) begin
      cyc(); idle();
      bus.wen = 2'b11;
      for (int p = 0; p < 2; p++) begin
        bus.waddr[p] = 5'(2 * i + p);
        bus.wd[p]    = ones ? '1 : base + 64'(2 * i + p);
        mdl[b][2 * i + p] = bus.wd[p];
      end
      sample();
    end
  endtask

  task automatic request(int id, bank_mode_e m);
    cyc(); idle();
    bus.bank_req_valid = 1'b1;
    bus.bank_req_id    = BW'(id);
    bus.bank_req_mode  = m;
    expect_val("req ready", OBS_READY, 0, 64'd1);
    sample();
  endtask

  task automatic do_switch(int id);
    request(id, BANK_SWITCH);
    cyc(); idle();
    expect_status($sformatf("switch%0d", id), id, 1'b0);
    sample();
  endtask

  initial begin
    for (int b = 0; b < FPR_BANKS; b++)
      for (int i = 0; i < 32; i++) mdl[b][i] = '0;
    idle();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;

    // Reset state
    cyc(); idle();
    expect_status("reset", 0, 1'b0);
    sample();
    read_all("reset", 0);

    // Write-port priority and bypass
    cyc(); idle();
    bus.wen = 2'b11; bus.waddr[0] = 5'd5; bus.waddr[1] = 5'd5;
    bus.wd[0] = 64'hAA; bus.wd[1] = 64'hBB;
    bus.raddr[0] = 5'd5; bus.rden[0] = 1'b1;
    expect_val("bypass f5", OBS_RD, 0, 64'hBB);
    sample();
    cyc(); idle();
    bus.wen = 2'b11; bus.waddr[0] = 5'd6; bus.waddr[1] = 5'd6;
    bus.wd[0] = 64'h0F; bus.wd[1] = 64'hF0;
    bus.raddr[0] = 5'd5; bus.rden[0] = 1'b1;
    bus.raddr[1] = 5'd5; bus.rden[1] = 1'b0;
    bus.raddr[2] = 5'd6; bus.rden[2] = 1'b0;
    expect_val("next f5", OBS_RD, 0, 64'hBB);
    expect_val("rden0 f5", OBS_RD, 1, 64'h0);
    expect_val("rden0 bypass f6", OBS_RD, 2, 64'h0);
    sample();
    cyc(); idle();
    bus.raddr[2] = 5'd6; bus.rden[2] = 1'b1;
    expect_val("no-or f6", OBS_RD, 2, 64'hF0);
    sample();

    // COPY bank0 -> bank2 with writes mirrored during the copy
    fill(0, 64'd1, 1'b0);
    request(2, BANK_COPY);
    for (int k = 1; k <= 33; k++) begin
      cyc(); idle();
      if (k == 5)  begin bus.wen[0] = 1'b1; bus.waddr[0] = 5'd31; bus.wd[0] = 64'h77;   mdl[0][31] = 64'h77;   end
      if (k == 10) begin bus.wen[1] = 1'b1; bus.waddr[1] = 5'd9;  bus.wd[1] = 64'h1234; mdl[0][9]  = 64'h1234; end
      if (k == 20) begin bus.wen[0] = 1'b1; bus.waddr[0] = 5'd2;  bus.wd[0] = 64'h99;   mdl[0][2]  = 64'h99;   end
      if (k >= 10 && k <= 12) begin
        bus.bank_req_valid = 1'b1; bus.bank_req_id = 2'd3; bus.bank_req_mode = BANK_SWITCH;
      end
      if (k <= 32) expect_status($sformatf("copy k%0d", k), 0, 1'b1);
      else         expect_status("copy done", 2, 1'b0);
      sample();
    end
    for (int i = 0; i < 32; i++) mdl[2][i] = mdl[0][i];
    read_all("copy", 2);

    // CLEAR bank1 prefilled with all-ones
    do_switch(1);
    fill(1, 64'd0, 1'b1);
    do_switch(0);
    request(1, BANK_CLEAR);
    for (int k = 1; k <= 9; k++) begin
      cyc(); idle();
      if (k <= 8) expect_status($sformatf("clear k%0d", k), 0, 1'b1);
      else        expect_status("clear done", 1, 1'b0);
      sample();
    end
    for (int i = 0; i < 32; i++) mdl[1][i] = '0;
    read_all("clear", 1);

    // SWITCH between banks retains per-bank contents
    do_switch(3);
    fill(3, 64'h300, 1'b0);
    do_switch(2);
    read_all("sw", 2);
    do_switch(3);
    read_all("sw", 3);
    do_switch(0);
    read_all("sw", 0);

    // COPY onto the active bank is a one-cycle no-op
    request(0, BANK_COPY);
    cyc(); idle();
    expect_status("copy-noop k1", 0, 1'b1);
    sample();
    cyc(); idle();
    expect_status("copy-noop k2", 0, 1'b0);
    sample();
    read_all("copy-noop", 0);

    // CLEAR of the active bank: same-cycle writes win over the clear
    request(0, BANK_CLEAR);
    for (int i = 0; i < 32; i++) mdl[0][i] = '0;
    for (int k = 1; k <= 9; k++) begin
      cyc(); idle();
      if (k == 1) begin bus.wen[1] = 1'b1; bus.waddr[1] = 5'd2;  bus.wd[1] = 64'h55; end
      if (k == 3) begin bus.wen[0] = 1'b1; bus.waddr[0] = 5'd10; bus.wd[0] = 64'h66; end
      if (k == 5) begin bus.wen[0] = 1'b1; bus.waddr[0] = 5'd1;  bus.wd[0] = 64'h44; end
      expect_status($sformatf("clr-act k%0d", k), 0, k <= 8);
      sample();
    end
    mdl[0][2] = 64'h55; mdl[0][10] = 64'h66; mdl[0][1] = 64'h44;
    read_all("clr-act", 0);

    // Reset in the middle of a COPY
    do_switch(3);
    request(1, BANK_COPY);
    for (int k = 1; k <= 10; k++) begin
      cyc(); idle();
      if (k == 10) rst = 1'b1;
      sample();
    end
    cyc(); idle();
    rst = 1'b0;
    expect_status("mid-rst", 0, 1'b0);
    sample();
    for (int b = 0; b < FPR_BANKS; b++)
      for (int i = 0; i < 32; i++) mdl[b][i] = '0;
    read_all("mid-rst", 0);
    do_switch(3);
    read_all("mid-rst", 3);
    do_switch(1);
    read_all("mid-rst", 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dec_fpr_mbank_ctl.md
# dec_fpr_mbank_ctl

Parametrised multi-port, multi-bank floating-point register file for the decode stage, successor to the fixed three-read/two-write banked FPR. It adds configurable port counts, deterministic write-port priority, optional write-to-read bypass, and a bank-management engine. The engine switches, copies or clears banks through a valid/ready request handshake, so software context switches do not need per-register moves. It sits between decode (read operands) and writeback (results).

## Interface
- FLEN, 64, register width in bits
- NREAD, 3, read ports
- NWRITE, 2, write ports
- FPR_BANKS, 4, register banks (power of two, ≥2)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads
- clk  in  1  clock, sole clock domain
- rst  in  1  synchronous, active-high reset
- raddr  in  NREAD×5  read addresses
- rden  in  NREAD  read enables
- rd  out  NREAD×FLEN  read data
- waddr  in  NWRITE×5  write addresses
- wen  in  NWRITE  write enables
- wd  in  NWRITE×FLEN  write data
- bank_req_valid  in  1  bank operation request
- bank_req_id  in  log2(FPR_BANKS)  target bank
- bank_req_mode  in  2  00 SWITCH, 01 COPY (current→target, then switch), 10 CLEAR (zero target, then switch), 11 reserved (treated as SWITCH)
- bank_req_ready  out  1  engine idle; request accepted when valid & ready
- cur_bank  out  log2(FPR_BANKS)  active bank
- busy  out  1  COPY/CLEAR in progress
- scan_mode  in  1  passed to flop cells

## Operation
- All 32 registers f0–f31 are writable. f0 is not hardwired to zero.
- Reads index cur_bank. A read with rden=0 returns 0.
- Write priority: when ports collide on one address, the higher-numbered port wins. Data is never ORed.
- BYPASS=1: a read of an address written this cycle returns the winning write data. BYPASS=0: the read returns the old value.
- Architectural writes always target cur_bank.
- FSM states IDLE, COPY, CLEAR. A 5-bit index counter idx is shared by COPY and CLEAR.
- IDLE, accept SWITCH: cur_bank←target next cycle; stay IDLE.
- IDLE, accept COPY: go to COPY, idx=0.
  - Each cycle, target[idx]←cur[idx], then idx++.
  - If a port writes address a in the same cycle, target[a] also receives the winning write data. This mirroring applies on every COPY cycle, not only for already-copied indices.
  - If idx==a in that cycle, the write data wins.
  - After idx=31: cur_bank←target, return to IDLE.
- IDLE, accept CLEAR: go to CLEAR, idx=0.
  - Each cycle, zero target[idx..idx+3], then idx+=4.
  - After the group 28–31: cur_bank←target, return to IDLE.
- Target equal to cur_bank:
  - SWITCH: no-op.
  - COPY: one-cycle no-op pass (ready low for 1 cycle, no data change).
  - CLEAR: clears the active bank. A same-cycle architectural write to a register being cleared wins.
- Requests while not ready are ignored. The requester holds valid.

## Timing
- Reset:
  - all banks zero
  - cur_bank=0, busy=0, bank_req_ready=1
  - rd=0
- Reset mid-COPY/CLEAR aborts the operation, zeroes all banks, and returns to IDLE.
- Read latency: combinational from raddr/rden and the current array state.
- Write latency: visible to reads the next cycle, or the same cycle when BYPASS=1.
- Request accepted at edge T:
  - SWITCH: cur_bank updates at T+1. busy never asserts.
  - COPY: busy and ready low during T+1..T+32. cur_bank=target, busy=0 and ready=1 at T+33.
  - CLEAR: busy during T+1..T+8. cur_bank=target at T+9.
  - COPY no-op (target==cur): busy high for one cycle (T+1). ready=1 again at T+2.
- idx wraps only by the FSM exiting. It never counts past 31.

## Structure
- Shared package dec_fpr_pkg holds:
  - bank_mode_e enum
  - FPR_NUM=32
  - CLEAR_PER_CYCLE=4
  - fsm state enum
- Sub-module dec_fpr_bank: one 32×FLEN bank with a per-register enable and NWRITE-priority write-data mux.
  - Instantiated FPR_BANKS times.
  - Copy/clear ports are driven by the top-level FSM.

## Test plan
- Reset, then read f0–f31 on all ports with rden=1 → all 0; cur_bank=0; ready=1.
- Write f5=0xAA via port0 and f5=0xBB via port1 in the same cycle → next-cycle read f5=0xBB. With BYPASS=1, a same-cycle read also returns 0xBB.
- Fill bank0 with f[i]=i+1; COPY to bank2 accepted at T.
  - During COPY, write f31=0x77 at T+5 → busy over T+1..T+32; cur_bank=2 at T+33.
  - Reads at T+33 return i+1, except f31=0x77.
- CLEAR to bank1 (pre-filled with 0xFF..), then read all → zero, with cur_bank=1 at T+9.
- SWITCH 0→3 with stored values, then switch back → each bank retains its own contents. Requests asserted during busy are not accepted.
- Assert rst at T+10 of a COPY → all reads 0, cur_bank=0, busy=0, ready=1 the cycle after reset.
